// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier: C = A*B mod (x^M + P), MSD-first, D bits per cycle.
// Optional `GF2M_MAC_EN adds acc_in, giving C = (A*B mod f) ^ acc_in.
module gf2m_digit_serial_mult #(
    parameter int M = 163,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic [M-1:0] P,
`ifdef GF2M_MAC_EN
    input  logic [M-1:0] acc_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] C,
    output logic         busy
);

    localparam int N  = (M + D - 1) / D;
    localparam int NW = N * D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            z_final;
    logic [M-1:0]    z;
    logic [M-1:0]    z_step;
    logic [M-1:0]    a_reg;
    logic [M-1:0]    p_reg;
    logic [NW-1:0]   b_reg;
    logic [D-1:0]    digit;
`ifdef GF2M_MAC_EN
    logic [M-1:0]    acc_reg;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state == DONE);
    assign digit     = b_reg[NW-1 -: D];

    // Horner over the digit bits: each step multiplies by x, folds x^M back as P,
    // then adds A if the digit bit is set. After D steps this is
    // reduce(Z*x^D) ^ reduce(A*digit), valid for any P.
    // NOTE: blocking assignments are intended here; z_step is rebuilt step by step
    // inside one combinational evaluation and is assigned first so no latch forms.
    always_comb begin
        z_step = z;
        for (int k = D - 1; k >= 0; k--) begin
            z_step = {z_step[M-2:0], 1'b0}
                   ^ (z_step[M-1] ? p_reg : '0)
                   ^ (digit[k]    ? a_reg : '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (z_final)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            z       <= '0;
            z_final <= 1'b0;
            C       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z       <= '0;
                        cnt     <= CW'(N - 1);
                        z_final <= 1'b0;
                    end
                end
                RUN: begin
                    if (!z_final) begin
                        z       <= z_step;
                        z_final <= (cnt == '0);
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end else begin
`ifdef GF2M_MAC_EN
                        C <= z ^ acc_reg;
`else
                        C <= z;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded at accept
    // before the FSM ever reads them, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_reg <= A;
            p_reg <= P;
            b_reg <= NW'(B);
`ifdef GF2M_MAC_EN
            acc_reg <= acc_in;
`endif
        end else if (state == RUN && !z_final) begin
            b_reg <= b_reg << D;
        end
    end

endmodule
